jux_axi_burst_master: RTL and testbench
=======================================

JUX_AXI_BURST_MASTER -- requirements
Module: jux_axi_burst_master

Interface
REQ-001 Parameters: DATA_WIDTH=2 (bus width 1<<DATA_WIDTH bytes); ADDR_WIDTH=32; ID_WIDTH=4; AXI4=1 (1: 8-bit AxLEN, 0: 4-bit AxLEN). LW = AXI4 ? 8 : 4; DB = 8<<DATA_WIDTH.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-005 cmd_write  input  1  1 = write burst, 0 = read burst.
REQ-006 cmd_addr  input  ADDR_WIDTH  burst start address.
REQ-007 cmd_len  input  LW  beats minus one.
REQ-008 cmd_burst  input  2  AxBURST value; 00 FIXED, 01 INCR, 10 WRAP.
REQ-009 cmd_id  input  ID_WIDTH  AxID value.
REQ-010 wd_valid / wd_ready  input / output  1 / 1  write-data stream handshake.
REQ-011 wd_data / wd_strb  input  DB / DB/8  write beat payload and byte strobes.
REQ-012 rd_valid / rd_ready  output / input  1 / 1  read-data stream handshake.
REQ-013 rd_data / rd_last  output  DB / 1  read beat payload; final-beat flag.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 done_resp / done_err  output  2 / 1  burst response; protocol-error flag.
REQ-016 AXI master ports, AXI naming: AW awaddr, awsize, awburst, awid, awlen, awvalid (out), awready (in); W wdata, wstrb, wlast, wvalid (out), wready (in); B bid, bresp, bvalid (in), bready (out); AR araddr, arsize, arburst, arid, arlen, arvalid (out), arready (in); R rdata, rid, rresp, rlast, rvalid (in), rready (out).

Function
REQ-017 The FSM SHALL have states IDLE, AW, W, B, AR, R; cmd_ready = (state==IDLE).
REQ-018 In IDLE, the cmd handshake SHALL register addr/len/burst/id and go to AW (write) or AR (read).
REQ-019 In AW/AR, the address channel SHALL drive the registered fields with awsize = arsize = DATA_WIDTH; AxVALID SHALL stay high with stable fields until AxREADY; the handshake SHALL move to W or R respectively.
REQ-020 W is a combinational pass-through: wvalid = (state==W) & wd_valid; wd_ready = (state==W) & wready; wdata/wstrb = wd_data/wd_strb.
REQ-021 An LW-bit beat counter SHALL clear on entering W/R and increment per data handshake; wlast = (state==W) & (beat==len).
REQ-022 Write handshake with beat==len SHALL go to B; bready = (state==B); B handshake SHALL go to IDLE.
REQ-023 R is a pass-through: rready = (state==R) & rd_ready; rd_valid = (state==R) & rvalid; rd_data = rdata; rd_last = rlast.
REQ-024 Read handshake with beat==len SHALL go to IDLE.
REQ-025 done SHALL pulse high for exactly 1 cycle, on the cycle after the final B or R handshake; a new command SHALL be acceptable in that same cycle.
REQ-026 done_resp, write: bresp. Read: first non-00 rresp of the burst, else 00.
REQ-027 done_err SHALL be 1 if: bid != id; any rid != id; rlast=1 at beat != len; or rlast=0 at beat==len.
REQ-028 done_resp and done_err SHALL hold until the next done pulse.
REQ-029 Exactly one transaction SHALL be outstanding; cmd_valid outside IDLE SHALL be ignored (cmd_ready=0).
REQ-030 The block SHALL not compute beat addresses; burst addressing is the slave's responsibility.
REQ-031 In R, a response beat arriving while rd_ready=0 SHALL be stalled via rready=0 and never dropped.

Reset
REQ-032 rstn low SHALL immediately force state IDLE, beat 0, awvalid=wvalid=bready=arvalid=rready=0, done=0, done_resp=00, done_err=0, cmd_ready=1.
REQ-033 Reset mid-burst SHALL abandon the transaction with no done pulse; after release the block SHALL accept a new command.

Verification
REQ-034 Write INCR addr 0x100, len 3, id 5, wd_data 0x11111111..0x44444444, strb F, slave always ready -> awlen=3; 4 W beats; wlast only on the 4th; done=1 one cycle after the B handshake; done_resp=00, done_err=0.
REQ-035 Read INCR 0x100, len 3, rd_ready=1 -> rd_data 0x11111111..0x44444444 in order; rd_last on beat 4; done next cycle; done_err=0.
REQ-036 Read len 1 with rd_ready toggled 1,0,0,1 -> rready tracks rd_ready; both beats delivered exactly once; no loss.
REQ-037 Slave returns bid=6 for id 5 -> done_err=1, done_resp=bresp.
REQ-038 Read len 2 where the slave asserts rlast on beat 2 -> done_err=1.
REQ-039 rstn pulsed low during the 2nd W beat of a len-3 write -> all valids 0 immediately; no done; a following read of len 0 completes with done_err=0.

Source files
------------

// File: rtl/jux_axi_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : jux_axi_burst_master
// Purpose  : Single-outstanding AXI3/AXI4 burst master. A command (write or
//            read burst) is taken on cmd_valid/cmd_ready. The address phase is
//            issued on AW or AR. The data phase is a combinational pass-through
//            between the local wd_*/rd_* streams and the AXI W/R channels.
//            On completion a one-cycle done pulse reports the response and a
//            protocol-error flag.
// Ports    : clk, rstn (async, active-low)
//            cmd_*   : command handshake (write, addr, len, burst, id)
//            wd_*    : local write-data stream in  (valid/ready/data/strb)
//            rd_*    : local read-data stream out  (valid/ready/data/last)
//            done, done_resp, done_err : completion status
//            aw*/w*/b*/ar*/r* : AXI master channels
// Revision : 1.0 - initial release
// ============================================================================
module jux_axi_burst_master #(
   parameter int DATA_WIDTH = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int AXI4       = 1,
   localparam int LW        = (AXI4 != 0) ? 8 : 4,
   localparam int DB        = 8 << DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rstn,
   // command
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LW-1:0]         cmd_len,
   input  logic [1:0]            cmd_burst,
   input  logic [ID_WIDTH-1:0]   cmd_id,
   // local write data
   input  logic                  wd_valid,
   output logic                  wd_ready,
   input  logic [DB-1:0]         wd_data,
   input  logic [DB/8-1:0]       wd_strb,
   // local read data
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [DB-1:0]         rd_data,
   output logic                  rd_last,
   // completion
   output logic                  done,
   output logic [1:0]            done_resp,
   output logic                  done_err,
   // AXI AW
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic [2:0]            awsize,
   output logic [1:0]            awburst,
   output logic [ID_WIDTH-1:0]   awid,
   output logic [LW-1:0]         awlen,
   output logic                  awvalid,
   input  logic                  awready,
   // AXI W
   output logic [DB-1:0]         wdata,
   output logic [DB/8-1:0]       wstrb,
   output logic                  wlast,
   output logic                  wvalid,
   input  logic                  wready,
   // AXI B
   input  logic [ID_WIDTH-1:0]   bid,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready,
   // AXI AR
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [2:0]            arsize,
   output logic [1:0]            arburst,
   output logic [ID_WIDTH-1:0]   arid,
   output logic [LW-1:0]         arlen,
   output logic                  arvalid,
   input  logic                  arready,
   // AXI R
   input  logic [DB-1:0]         rdata,
   input  logic [ID_WIDTH-1:0]   rid,
   input  logic [1:0]            rresp,
   input  logic                  rlast,
   input  logic                  rvalid,
   output logic                  rready
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AW   = 3'd1,
      S_W    = 3'd2,
      S_B    = 3'd3,
      S_AR   = 3'd4,
      S_R    = 3'd5
   } state_t;

   state_t                r_state;
   logic [LW-1:0]         r_beat;
   logic [LW-1:0]         r_len;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [1:0]            r_burst;
   logic [ID_WIDTH-1:0]   r_id;
   logic                  r_done;
   logic [1:0]            r_done_resp;
   logic                  r_done_err;
   logic [1:0]            r_rresp_acc;   // first non-OKAY rresp seen so far
   logic                  r_rerr_acc;    // sticky read protocol error

   logic                  w_last_beat;
   logic                  w_w_hs;
   logic                  w_r_hs;
   logic                  w_rbeat_err;
   logic [1:0]            w_rresp_next;

   // ---------------------------------------------------------------------
   // Outputs decoded from the registered state; the data channels are
   // straight pass-throughs gated by the current state.
   // ---------------------------------------------------------------------
   assign cmd_ready = (r_state == S_IDLE);

   assign awaddr  = r_addr;
   assign awsize  = 3'(DATA_WIDTH);
   assign awburst = r_burst;
   assign awid    = r_id;
   assign awlen   = r_len;
   assign awvalid = (r_state == S_AW);

   assign araddr  = r_addr;
   assign arsize  = 3'(DATA_WIDTH);
   assign arburst = r_burst;
   assign arid    = r_id;
   assign arlen   = r_len;
   assign arvalid = (r_state == S_AR);

   assign w_last_beat = (r_beat == r_len);

   assign wvalid   = (r_state == S_W) & wd_valid;
   assign wd_ready = (r_state == S_W) & wready;
   assign wdata    = wd_data;
   assign wstrb    = wd_strb;
   assign wlast    = (r_state == S_W) & w_last_beat;

   assign bready   = (r_state == S_B);

   // rready follows the local consumer, so an unconsumed beat stays on the
   // R channel instead of being lost.
   assign rready   = (r_state == S_R) & rd_ready;
   assign rd_valid = (r_state == S_R) & rvalid;
   assign rd_data  = rdata;
   assign rd_last  = rlast;

   assign done      = r_done;
   assign done_resp = r_done_resp;
   assign done_err  = r_done_err;

   assign w_w_hs = wvalid & wready;
   assign w_r_hs = rvalid & rready;

   // Wrong ID, or rlast disagreeing with the beat count, marks the burst bad.
   assign w_rbeat_err  = (rid != r_id) | (rlast != w_last_beat);
   assign w_rresp_next = (r_rresp_acc != 2'b00) ? r_rresp_acc : rresp;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_beat      <= '0;
         r_len       <= '0;
         r_addr      <= '0;
         r_burst     <= 2'b00;
         r_id        <= '0;
         r_done      <= 1'b0;
         r_done_resp <= 2'b00;
         r_done_err  <= 1'b0;
         r_rresp_acc <= 2'b00;
         r_rerr_acc  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_addr      <= cmd_addr;
                  r_len       <= cmd_len;
                  r_burst     <= cmd_burst;
                  r_id        <= cmd_id;
                  r_rresp_acc <= 2'b00;
                  r_rerr_acc  <= 1'b0;
                  r_state     <= cmd_write ? S_AW : S_AR;
               end
            end
            S_AW: begin
               if (awready) begin
                  r_beat  <= '0;
                  r_state <= S_W;
               end
            end
            S_W: begin
               if (w_w_hs) begin
                  if (w_last_beat) begin
                     r_state <= S_B;
                  end else begin
                     r_beat <= r_beat + LW'(1);
                  end
               end
            end
            S_B: begin
               if (bvalid) begin
                  r_done      <= 1'b1;
                  r_done_resp <= bresp;
                  r_done_err  <= (bid != r_id);
                  r_state     <= S_IDLE;
               end
            end
            S_AR: begin
               if (arready) begin
                  r_beat  <= '0;
                  r_state <= S_R;
               end
            end
            S_R: begin
               if (w_r_hs) begin
                  r_rresp_acc <= w_rresp_next;
                  r_rerr_acc  <= r_rerr_acc | w_rbeat_err;
                  if (w_last_beat) begin
                     r_done      <= 1'b1;
                     r_done_resp <= w_rresp_next;
                     r_done_err  <= r_rerr_acc | w_rbeat_err;
                     r_state     <= S_IDLE;
                  end else begin
                     r_beat <= r_beat + LW'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jux_axi_burst_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_jux_axi_burst_master
// Purpose  : Self-checking bench. The bench plays both the local user and the
//            AXI slave; a byte-addressed memory plus per-burst beat lists form
//            the reference for data, responses and error flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jux_axi_burst_master;

   localparam int DATA_WIDTH = 2;
   localparam int ADDR_WIDTH = 32;
   localparam int ID_WIDTH   = 4;
   localparam int AXI4       = 1;
   localparam int LW         = 8;
   localparam int DB         = 32;
   localparam int BUDGET     = 300;

   logic            clk, rstn;
   logic            cmd_valid, cmd_ready, cmd_write;
   logic [31:0]     cmd_addr;
   logic [7:0]      cmd_len;
   logic [1:0]      cmd_burst;
   logic [3:0]      cmd_id;
   logic            wd_valid, wd_ready;
   logic [31:0]     wd_data;
   logic [3:0]      wd_strb;
   logic            rd_valid, rd_ready;
   logic [31:0]     rd_data;
   logic            rd_last;
   logic            done;
   logic [1:0]      done_resp;
   logic            done_err;
   logic [31:0]     awaddr;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic [3:0]      awid;
   logic [7:0]      awlen;
   logic            awvalid, awready;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic            wlast, wvalid, wready;
   logic [3:0]      bid;
   logic [1:0]      bresp;
   logic            bvalid, bready;
   logic [31:0]     araddr;
   logic [2:0]      arsize;
   logic [1:0]      arburst;
   logic [3:0]      arid;
   logic [7:0]      arlen;
   logic            arvalid, arready;
   logic [31:0]     rdata;
   logic [3:0]      rid;
   logic [1:0]      rresp;
   logic            rlast, rvalid, rready;

   jux_axi_burst_master #(
      .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
      .ID_WIDTH(ID_WIDTH), .AXI4(AXI4)
   ) dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_burst(cmd_burst),
      .cmd_id(cmd_id),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
      .wd_strb(wd_strb),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
      .rd_last(rd_last),
      .done(done), .done_resp(done_resp), .done_err(done_err),
      .awaddr(awaddr), .awsize(awsize), .awburst(awburst), .awid(awid),
      .awlen(awlen), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
      .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arsize(arsize), .arburst(arburst), .arid(arid),
      .arlen(arlen), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rid(rid), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   int total = 0;
   int bad   = 0;
   int stall = 0;                      // percent of cycles a ready/valid is withheld
   bit exp_const = 1'b0;               // read data must be 0x11111111*(beat+1)
   logic [1:0] last_resp = 2'b00;      // last reported completion, must hold
   logic       last_err  = 1'b0;
   logic [7:0] mem [logic [31:0]];
   logic [31:0] wdat_q[$];
   logic [3:0]  wstrb_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      total++;
      bad++;
      $error("FAIL %s: got budget-expired want handshake", tag);
   endtask

   function automatic logic rnd();
      return ($urandom_range(0, 99) >= stall);
   endfunction

   // Address of beat i as the slave sees it for each burst type.
   function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len,
                                             input logic [1:0] burst, input int i);
      logic [31:0] size, base;
      if (burst == 2'b00) return a;
      if (burst == 2'b01) return a + 32'(i * 4);
      size = 32'((len + 1) * 4);
      base = a & ~(size - 32'd1);
      return base + ((a - base + 32'(i * 4)) % size);
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      logic [31:0] w;
      logic [31:0] ba;
      for (int b = 0; b < 4; b++) begin
         ba = (a & ~32'd3) + 32'(b);
         w[b*8 +: 8] = mem.exists(ba) ? mem[ba] : 8'h00;
      end
      return w;
   endfunction

   task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      for (int b = 0; b < 4; b++)
         if (s[b]) mem[(a & ~32'd3) + 32'(b)] = d[b*8 +: 8];
   endtask

   task automatic send_cmd(input bit wr, input logic [31:0] addr, input int len,
                           input logic [3:0] id, input logic [1:0] burst);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
      cmd_len = 8'(len); cmd_burst = burst; cmd_id = id;
      #1;
      chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
      @(negedge clk);
      // A second command offered while busy must be ignored.
      cmd_addr = ~addr; cmd_len = 8'(~len); cmd_id = ~id;
   endtask

   task automatic check_done(input logic [1:0] er, input logic ee);
      #1;
      chk("done_pulse", 64'(done), 64'(1));
      chk("done_resp", 64'(done_resp), 64'(er));
      chk("done_err", 64'(done_err), 64'(ee));
      chk("cmd_ready_at_done", 64'(cmd_ready), 64'(1));
      last_resp = er;
      last_err  = ee;
   endtask

   task automatic do_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                           input logic [1:0] burst, input logic [3:0] b_id,
                           input logic [1:0] b_resp, input int rst_at);
      bit hs;
      int i;
      send_cmd(1'b1, addr, len, id, burst);
      for (int cyc = 0; ; cyc++) begin
         awready = rnd();
         #1;
         if (cyc == 0) begin
            chk("done_one_cycle", 64'(done), 64'(0));
            chk("done_resp_hold", 64'(done_resp), 64'(last_resp));
            chk("done_err_hold", 64'(done_err), 64'(last_err));
         end
         chk("awvalid", 64'(awvalid), 64'(1));
         chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));
         chk("awaddr", 64'(awaddr), 64'(addr));
         chk("awlen", 64'(awlen), 64'(len));
         chk("awid", 64'(awid), 64'(id));
         chk("awburst", 64'(awburst), 64'(burst));
         chk("awsize", 64'(awsize), 64'(2));
         hs = awvalid & awready;
         @(negedge clk);
         awready = 1'b0;
         if (hs) break;
         if (cyc >= BUDGET) begin timeout("aw_timeout"); cmd_valid = 1'b0; return; end
      end
      cmd_valid = 1'b0;
      i = 0;
      for (int cyc = 0; i <= len; cyc++) begin
         wd_data = wdat_q[i];
         wd_strb = wstrb_q[i];
         if (i == rst_at) begin
            wd_valid = 1'b1; wready = 1'b1;
            #1;
            chk("rst_wvalid_before", 64'(wvalid), 64'(1));
            rstn = 1'b0;
            #1;
            chk("rst_awvalid", 64'(awvalid), 64'(0));
            chk("rst_wvalid", 64'(wvalid), 64'(0));
            chk("rst_bready", 64'(bready), 64'(0));
            chk("rst_arvalid", 64'(arvalid), 64'(0));
            chk("rst_rready", 64'(rready), 64'(0));
            chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
            chk("rst_done", 64'(done), 64'(0));
            chk("rst_done_resp", 64'(done_resp), 64'(0));
            chk("rst_done_err", 64'(done_err), 64'(0));
            wd_valid = 1'b0; wready = 1'b0;
            @(negedge clk);
            rstn = 1'b1;
            last_resp = 2'b00;
            last_err  = 1'b0;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               #1;
               chk("no_done_after_abort", 64'(done), 64'(0));
               chk("idle_after_abort", 64'(cmd_ready), 64'(1));
            end
            return;
         end
         wd_valid = rnd();
         wready   = rnd();
         #1;
         chk("wvalid", 64'(wvalid), 64'(wd_valid));
         chk("wd_ready", 64'(wd_ready), 64'(wready));
         chk("wdata", 64'(wdata), 64'(wd_data));
         chk("wstrb", 64'(wstrb), 64'(wd_strb));
         chk("wlast", 64'(wlast), 64'(i == len));
         chk("cmd_ready_w", 64'(cmd_ready), 64'(0));
         hs = wvalid & wready;
         if (hs) begin
            mem_wr(beat_addr(addr, len, burst, i), wd_data, wd_strb);
            i++;
         end
         @(negedge clk);
         wd_valid = 1'b0; wready = 1'b0;
         if (cyc >= BUDGET) begin timeout("w_timeout"); return; end
      end
      for (int cyc = 0; ; cyc++) begin
         bvalid = rnd(); bid = b_id; bresp = b_resp;
         #1;
         chk("bready", 64'(bready), 64'(1));
         chk("done_before_b", 64'(done), 64'(0));
         hs = bvalid & bready;
         @(negedge clk);
         bvalid = 1'b0;
         if (hs) break;
         if (cyc >= BUDGET) begin timeout("b_timeout"); return; end
      end
      check_done(b_resp, b_id != id);
   endtask

   task automatic do_read(input logic [31:0] addr, input int len, input logic [3:0] id,
                          input logic [1:0] burst, input int bad_rid_at, input int flip_last_at,
                          input bit rand_resp, input bit pattern);
      logic [31:0] d_q[$];
      logic [3:0]  id_q[$];
      logic [1:0]  rs_q[$];
      logic        ls_q[$];
      logic [1:0]  er;
      logic        ee;
      bit          hs;
      int          i, got;
      bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      // Reference: the beats the slave will return, and the status they imply.
      er = 2'b00; ee = 1'b0;
      for (int k = 0; k <= len; k++) begin
         d_q.push_back(mem_rd(beat_addr(addr, len, burst, k)));
         id_q.push_back((k == bad_rid_at) ? (id ^ 4'h1) : id);
         rs_q.push_back(rand_resp && ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
         ls_q.push_back((k == len) ^ (k == flip_last_at));
         if (er == 2'b00) er = rs_q[k];
         if (id_q[k] != id || ls_q[k] != (k == len)) ee = 1'b1;
      end
      send_cmd(1'b0, addr, len, id, burst);
      for (int cyc = 0; ; cyc++) begin
         arready = rnd();
         #1;
         if (cyc == 0) begin
            chk("done_one_cycle", 64'(done), 64'(0));
            chk("done_resp_hold", 64'(done_resp), 64'(last_resp));
            chk("done_err_hold", 64'(done_err), 64'(last_err));
         end
         chk("arvalid", 64'(arvalid), 64'(1));
         chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));
         chk("araddr", 64'(araddr), 64'(addr));
         chk("arlen", 64'(arlen), 64'(len));
         chk("arid", 64'(arid), 64'(id));
         chk("arburst", 64'(arburst), 64'(burst));
         chk("arsize", 64'(arsize), 64'(2));
         hs = arvalid & arready;
         @(negedge clk);
         arready = 1'b0;
         if (hs) break;
         if (cyc >= BUDGET) begin timeout("ar_timeout"); cmd_valid = 1'b0; return; end
      end
      cmd_valid = 1'b0;
      i = 0; got = 0;
      for (int cyc = 0; i <= len; cyc++) begin
         rvalid   = pattern ? 1'b1 : rnd();
         rd_ready = pattern ? pat[cyc % 4] : rnd();
         rdata = d_q[i]; rid = id_q[i]; rresp = rs_q[i]; rlast = ls_q[i];
         #1;
         chk("rready", 64'(rready), 64'(rd_ready));
         chk("rd_valid", 64'(rd_valid), 64'(rvalid));
         chk("rd_data", 64'(rd_data), 64'(d_q[i]));
         chk("rd_last", 64'(rd_last), 64'(ls_q[i]));
         chk("done_during_r", 64'(done), 64'(0));
         if (exp_const) chk("rd_data_const", 64'(rd_data), 64'(32'h11111111 * 32'(i + 1)));
         hs = rvalid & rready;
         if (hs) begin i++; got++; end
         @(negedge clk);
         rvalid = 1'b0; rd_ready = 1'b0;
         if (cyc >= BUDGET) begin timeout("r_timeout"); return; end
      end
      chk("r_beats_delivered", 64'(got), 64'(len + 1));
      check_done(er, ee);
   endtask

   task automatic fill_wdata(input int len, input bit counting);
      wdat_q.delete(); wstrb_q.delete();
      for (int k = 0; k <= len; k++) begin
         wdat_q.push_back(counting ? 32'h11111111 * 32'(k + 1) : $urandom);
         wstrb_q.push_back(counting ? 4'hF : 4'($urandom_range(1, 15)));
      end
   endtask

   initial begin
      rstn = 1'b0;
      cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_burst = 0; cmd_id = 0;
      wd_valid = 0; wd_data = 0; wd_strb = 0; rd_ready = 0;
      awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0; arready = 0;
      rdata = 0; rid = 0; rresp = 0; rlast = 0; rvalid = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("reset_awvalid", 64'(awvalid), 64'(0));
      chk("reset_arvalid", 64'(arvalid), 64'(0));
      chk("reset_bready", 64'(bready), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      chk("reset_done_resp", 64'(done_resp), 64'(0));
      chk("reset_done_err", 64'(done_err), 64'(0));
      rstn = 1'b1;
      @(negedge clk);

      // INCR write of four counting words, slave always ready.
      stall = 0;
      fill_wdata(3, 1'b1);
      do_write(32'h100, 3, 4'd5, 2'b01, 4'd5, 2'b00, -1);
      // Read them back in order.
      exp_const = 1'b1;
      do_read(32'h100, 3, 4'd5, 2'b01, -1, -1, 1'b0, 1'b0);
      exp_const = 1'b0;
      // Consumer back-pressure 1,0,0,1 on a two-beat read.
      do_read(32'h100, 1, 4'd5, 2'b01, -1, -1, 1'b0, 1'b1);
      // Wrong BID with SLVERR.
      fill_wdata(1, 1'b0);
      do_write(32'h180, 1, 4'd5, 2'b01, 4'd6, 2'b10, -1);
      // Early rlast on beat 2 of a three-beat read.
      do_read(32'h100, 2, 4'd5, 2'b01, -1, 1, 1'b0, 1'b0);
      // Reset during the second W beat, then a single-beat read.
      fill_wdata(3, 1'b0);
      do_write(32'h200, 3, 4'd5, 2'b01, 4'd5, 2'b00, 1);
      do_read(32'h200, 0, 4'd5, 2'b01, -1, -1, 1'b0, 1'b0);

      // Randomised traffic with stalls on every channel.
      stall = 30;
      for (int t = 0; t < 24; t++) begin
         logic [1:0]  bu;
         int          ln;
         logic [3:0]  id;
         logic [31:0] a;
         bu = 2'($urandom_range(0, 2));
         ln = (bu == 2'b10) ? ((2 << $urandom_range(0, 3)) - 1) : int'($urandom_range(0, 15));
         id = 4'($urandom_range(0, 15));
         a  = 32'h1000 + 32'($urandom_range(0, 63) * 4);
         if ($urandom_range(0, 1) == 1) begin
            fill_wdata(ln, 1'b0);
            do_write(a, ln, id, bu,
                     ($urandom_range(0, 4) == 0) ? (id ^ 4'h3) : id,
                     2'($urandom_range(0, 3)), -1);
         end else begin
            do_read(a, ln, id, bu,
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, ln)) : -1,
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, ln)) : -1,
                    1'b1, 1'b0);
         end
      end

      @(negedge clk);
      #1;
      chk("final_no_done", 64'(done), 64'(0));
      chk("final_idle", 64'(cmd_ready), 64'(1));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
